// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display scanner.
//   conv_state_t : conversion FSM states (IDLE -> SHIFT -> COMMIT -> IDLE)
//   NDIG_DEF     : default digit count
//   BCD_W        : BCD accumulator width for the default digit count
//   max_dec()    : largest value representable in ndig decimal digits
package display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    localparam int NDIG_DEF = 4;
    localparam int BCD_W    = 4 * NDIG_DEF;

    // 10**ndig - 1; loop form keeps it usable in constant expressions
    function automatic int max_dec(input int ndig);
        int r;
        r = 1;
        for (int i = 0; i < ndig; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/display_bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter with its control FSM.
// A load in IDLE captures value; SHIFT runs WIDTH add-3/shift steps; COMMIT
// publishes the result to bcd (or all nines when the value does not fit).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load       : start strobe, honoured only in IDLE
//   value      : binary input, sampled when load is accepted
//   busy       : conversion in progress (registered)
//   overflow   : last accepted value exceeded NDIG decimal digits
//   bcd        : display register, NDIG packed BCD nibbles, digit 0 in [3:0]
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int NDIG  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WIDTH-1:0]  value,
    output logic              busy,
    output logic              overflow,
    output logic [4*NDIG-1:0] bcd
);

    localparam int          BW   = 4 * NDIG;
    localparam int          CW   = $clog2(WIDTH + 1);
    localparam logic [31:0] MAXV = 32'(max_dec(NDIG));

    conv_state_t      state;
    logic [WIDTH-1:0] bin;
    logic [BW-1:0]    acc;
    logic [BW-1:0]    adj;
    logic [CW-1:0]    cnt;
    logic             ovf_cap;

    // Per-nibble add-3 correction applied before every shift
    for (genvar i = 0; i < NDIG; i++) begin : g_adj
        assign adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3
                                                       : acc[4*i +: 4];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bin      <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_cap  <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            bcd      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin     <= value;
                        acc     <= '0;
                        cnt     <= '0;
                        // range decision is made on the raw input, not the BCD result
                        ovf_cap <= (32'(value) > MAXV);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= {adj[BW-2:0], bin[WIDTH-1]};
                    bin <= {bin[WIDTH-2:0], 1'b0};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    bcd      <= ovf_cap ? {NDIG{4'd9}} : acc;
                    overflow <= ovf_cap;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Multiplexed 7-segment display driver. Converts a loaded binary value to BCD
// and scans the digits one per SCAN_DIV clocks, with optional leading-zero
// blanking done purely through the digit selects.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   value      : binary value to display, sampled on an accepted load
//   load       : strobe, accepted only while busy is low
//   busy       : conversion in progress
//   overflow   : last accepted value did not fit in NDIG decimal digits
//   digit      : BCD digit of the selected position, to the segment decoder
//   digit_sel  : active-low one-hot digit common enable (all ones = dark)
module display_scanner
    import display_pkg::*;
#(
    parameter int WIDTH    = 14,
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    output logic             busy,
    output logic             overflow,
    output logic [3:0]       digit,
    output logic [NDIG-1:0]  digit_sel
);

    localparam int BW = 4 * NDIG;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [BW-1:0]          bcd;
    logic [NDIG-1:0][3:0]   nib;
    logic [NDIG-1:0]        blank;
    logic [PW-1:0]          pre;
    logic [IW-1:0]          idx;
    logic [3:0]             digit_nxt;
    logic [NDIG-1:0]        sel_nxt;

    bin2bcd_seq #(
        .WIDTH (WIDTH),
        .NDIG  (NDIG)
    ) u_conv (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value    (value),
        .busy     (busy),
        .overflow (overflow),
        .bcd      (bcd)
    );

    assign nib = bcd;

    // Position i is a leading zero when it and every more significant nibble
    // are zero; the rightmost position always shows.
    for (genvar i = 0; i < NDIG; i++) begin : g_blank
        if (i == 0) begin : g_lsd
            assign blank[i] = 1'b0;
        end else begin : g_upper
            assign blank[i] = (BLANK_LZ != 0) && (bcd[BW-1:4*i] == '0);
        end
    end

    // Scan prescaler and digit index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PW'(SCAN_DIV - 1)) begin
            pre <= '0;
            idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
        end else begin
            pre <= pre + PW'(1);
        end
    end

    always_comb begin
        sel_nxt   = '1;
        digit_nxt = 4'd0;
        if (!blank[idx]) begin
            sel_nxt   = ~(NDIG'(1) << idx);
            digit_nxt = nib[idx];
        end
    end

    // Select and digit come from the same index and display register and are
    // registered together, so a select is never paired with another slot's digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit     <= 4'd0;
            digit_sel <= '1;
        end else begin
            digit     <= digit_nxt;
            digit_sel <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

    localparam int WIDTH = 14;
    localparam int NDIG  = 4;
    localparam int SD    = 4;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             load  = 1'b0;
    logic [WIDTH-1:0] value = '0;
    logic             busy;
    logic             overflow;
    logic [3:0]       digit;
    logic [NDIG-1:0]  digit_sel;

    int n_run  = 0;
    int n_fail = 0;
    int sb[$];
    int ec;

    always #5 clk = ~clk;

    display_scanner #(
        .WIDTH    (WIDTH),
        .NDIG     (NDIG),
        .SCAN_DIV (SD),
        .BLANK_LZ (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .load      (load),
        .busy      (busy),
        .overflow  (overflow),
        .digit     (digit),
        .digit_sel (digit_sel)
    );

    // Clock edges since reset release; outputs after edge k show slot ((k-1)/SD)%NDIG
    always @(posedge clk or posedge reset) begin
        if (reset) ec <= 0;
        else       ec <= ec + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pow10(input int p);
        int r;
        r = 1;
        for (int i = 0; i < p; i++) r = r * 10;
        return r;
    endfunction

    function automatic int exp_dig(input int v, input int p);
        if (v > 9999) return 9;
        return (v / pow10(p)) % 10;
    endfunction

    function automatic bit exp_blank(input int v, input int p);
        if (p == 0 || v > 9999) return 1'b0;
        return v < pow10(p);
    endfunction

    task automatic check_frame(input int v);
        int p;
        logic [NDIG-1:0] es;
        for (int c = 0; c < NDIG * SD; c++) begin
            @(negedge clk);
            p  = ((ec - 1) / SD) % NDIG;
            es = exp_blank(v, p) ? 4'hf : ~(4'b0001 << p);
            chk($sformatf("sel[%0d] v=%0d", p, v), 32'(digit_sel), 32'(es));
            chk($sformatf("dig[%0d] v=%0d", p, v), 32'(digit),
                exp_blank(v, p) ? 0 : exp_dig(v, p));
        end
    endtask

    task automatic start_conv(input int v);
        @(negedge clk);
        value = WIDTH'(v);
        load  = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic finish_conv(input bit chk_len);
        int cnt;
        int v;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        if (chk_len) chk("busy_len", cnt, WIDTH + 1);
        else if (cnt >= 200) chk("busy_timeout", 1, 0);
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            v = sb.pop_front();
            chk($sformatf("ovf v=%0d", v), 32'(overflow), (v > 9999) ? 1 : 0);
            check_frame(v);
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf",  32'(overflow), 0);
        chk("rst_sel",  32'(digit_sel), 32'hf);
        chk("rst_dig",  32'(digit), 0);
        reset = 1'b0;
        check_frame(0);

        start_conv(1234);  finish_conv(1);
        start_conv(7);     finish_conv(1);
        start_conv(12000); finish_conv(1);
        start_conv(5);     finish_conv(1);

        // load while busy is dropped; the first value stays
        start_conv(100);
        @(negedge clk);
        value = WIDTH'(42);
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        finish_conv(0);
        start_conv(42);    finish_conv(1);

        // reset during SHIFT aborts and clears the display
        start_conv(3333);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_sel",  32'(digit_sel), 32'hf);
        chk("mid_rst_dig",  32'(digit), 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        check_frame(0);

        start_conv(999);   finish_conv(1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
